// File: rtl/cluster_chk_pkg.sv
// Shared types and defaults for the cluster output checker.
// State encodings and default word/counter widths live here.
package cluster_chk_pkg;

   typedef logic [1:0] chk_state_t;

   localparam chk_state_t ST_IDLE = 2'd0;
   localparam chk_state_t ST_RUN  = 2'd1;
   localparam chk_state_t ST_HALT = 2'd2;

   localparam int unsigned W_DEF     = 64;
   localparam int unsigned CNT_W_DEF = 32;
   localparam int unsigned HIST_W    = 16;

endpackage

// File: rtl/cluster_output_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cluster_output_checker.sv
// Two-stage compare of predicted vs golden output words with statistics.
// Define CHECKER_BITHIST_EN to add per-bit mismatch counters.
module cluster_output_checker
   import cluster_chk_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic             halt_on_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_pred,
   input  logic [W-1:0]     in_gold,
   output logic [CNT_W-1:0] test_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             first_err_vld,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [W-1:0]     first_err_mask,
   output logic [1:0]       state
`ifdef CHECKER_BITHIST_EN
   ,
   input  logic [$clog2(W)-1:0] bit_sel,
   output logic [HIST_W-1:0]    bit_err_cnt
`endif
);

   chk_state_t       state_q, state_d;
   logic             s1_vld_q, s1_vld_d;
   logic [W-1:0]     s1_mask_q, s1_mask_d;
   logic             fe_vld_q, fe_vld_d;
   logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
   logic [W-1:0]     fe_mask_q, fe_mask_d;
   logic             hs;
   logic             s2_err;

   assign in_ready = (state_q == ST_RUN);
   assign hs       = in_valid & in_ready;
   assign s2_err   = s1_vld_q & (|s1_mask_q);

   // clear has priority over a halt seen in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (clear) begin
               state_d = ST_IDLE;
            end else if (halt_on_err && s2_err) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: if (clear) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s1_vld_d  = hs & ~clear;
      s1_mask_d = s1_mask_q;
      if (clear) begin
         s1_mask_d = '0;
      end else if (hs) begin
         s1_mask_d = in_pred ^ in_gold;
      end
   end

   always_comb begin
      fe_vld_d  = fe_vld_q;
      fe_idx_d  = fe_idx_q;
      fe_mask_d = fe_mask_q;
      if (clear) begin
         fe_vld_d  = 1'b0;
         fe_idx_d  = '0;
         fe_mask_d = '0;
      end else if (s2_err && !fe_vld_q) begin
         fe_vld_d  = 1'b1;
         fe_idx_d  = test_cnt;
         fe_mask_d = s1_mask_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         s1_vld_q  <= 1'b0;
         s1_mask_q <= '0;
         fe_vld_q  <= 1'b0;
         fe_idx_q  <= '0;
         fe_mask_q <= '0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= s1_vld_d;
         s1_mask_q <= s1_mask_d;
         fe_vld_q  <= fe_vld_d;
         fe_idx_q  <= fe_idx_d;
         fe_mask_q <= fe_mask_d;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_test_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (s1_vld_q),
      .clr_i (clear),
      .cnt_o (test_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (s2_err),
      .clr_i (clear),
      .cnt_o (err_cnt)
   );

   assign first_err_vld  = fe_vld_q;
   assign first_err_idx  = fe_idx_q;
   assign first_err_mask = fe_mask_q;
   assign state          = state_q;

`ifdef CHECKER_BITHIST_EN
   logic [HIST_W-1:0] hist [W];
   logic [HIST_W-1:0] bit_err_cnt_q;

   for (genvar i = 0; i < W; i++) begin : g_hist
      sat_counter #(.WIDTH(HIST_W)) u_bit_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc_i (s1_vld_q & s1_mask_q[i]),
         .clr_i (clear),
         .cnt_o (hist[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_err_cnt_q <= '0;
      end else begin
         bit_err_cnt_q <= hist[bit_sel];
      end
   end

   assign bit_err_cnt = bit_err_cnt_q;
`endif

endmodule

// File: tb/tb_cluster_output_checker.sv
// Randomized bench for cluster_output_checker against a sample-list model.
// Define CHECKER_BITHIST_EN to also exercise the per-bit histogram.
module tb_cluster_output_checker;

   localparam int W     = 64;
   localparam int CNT_W = 32;
   localparam int BUDGET = 2000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             clear;
   logic             halt_on_err;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_pred;
   logic [W-1:0]     in_gold;
   logic [CNT_W-1:0] test_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             first_err_vld;
   logic [CNT_W-1:0] first_err_idx;
   logic [W-1:0]     first_err_mask;
   logic [1:0]       state;
`ifdef CHECKER_BITHIST_EN
   logic [5:0]       bit_sel;
   logic [15:0]      bit_err_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] op[$];
   logic [63:0] og[$];

   always #5 clk = ~clk;

   cluster_output_checker #(.W(W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .clear          (clear),
      .halt_on_err    (halt_on_err),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pred        (in_pred),
      .in_gold        (in_gold),
      .test_cnt       (test_cnt),
      .err_cnt        (err_cnt),
      .first_err_vld  (first_err_vld),
      .first_err_idx  (first_err_idx),
      .first_err_mask (first_err_mask),
      .state          (state)
`ifdef CHECKER_BITHIST_EN
      ,
      .bit_sel        (bit_sel),
      .bit_err_cnt    (bit_err_cnt)
`endif
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_test_cnt"}, 64'(test_cnt), 64'd0);
      chk({pfx, "_err_cnt"}, 64'(err_cnt), 64'd0);
      chk({pfx, "_fe_vld"}, 64'(first_err_vld), 64'd0);
      chk({pfx, "_fe_idx"}, 64'(first_err_idx), 64'd0);
      chk({pfx, "_fe_mask"}, first_err_mask, 64'd0);
      chk({pfx, "_state"}, 64'(state), 64'd0);
      chk({pfx, "_in_ready"}, 64'(in_ready), 64'd0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check_zero("clr");
   endtask

   // Offers op/og in order; model decides acceptance from the halt rule:
   // a mismatch accepted in cycle c stops acceptance from cycle c+2.
   task automatic run_stream(input bit halt,
                             input int vpct,
                             input logic [31:0] base);
      int idx, cyc, halt_cyc, nacc, nerr, fidx;
      logic [63:0] fmask, tc;
      bit mready, v;
      idx = 0; cyc = 0; halt_cyc = -1;
      nacc = 0; nerr = 0; fidx = -1;
      fmask = '0;
      halt_on_err = halt;
      while (idx < op.size() && cyc < BUDGET) begin
         mready = !(halt_cyc >= 0 && cyc >= halt_cyc);
         chk("in_ready", 64'(in_ready), 64'(mready));
         if (!mready) break;
         v = ($urandom_range(99) < vpct);
         in_valid = v;
         in_pred  = op[idx];
         in_gold  = og[idx];
         if (v) begin
            if (op[idx] != og[idx]) begin
               nerr++;
               if (fidx < 0) begin
                  fidx  = nacc;
                  fmask = op[idx] ^ og[idx];
                  if (halt) halt_cyc = cyc + 2;
               end
            end
            nacc++;
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= BUDGET) chk("stream_budget", 64'(idx), 64'(op.size()));
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tc = 64'(base) + 64'(nacc);
      if (tc > 64'hFFFF_FFFF) tc = 64'hFFFF_FFFF;
      chk("test_cnt", 64'(test_cnt), tc);
      chk("err_cnt", 64'(err_cnt), 64'(nerr));
      chk("fe_vld", 64'(first_err_vld), 64'(fidx >= 0));
      chk("fe_idx", 64'(first_err_idx),
          (fidx >= 0) ? 64'(base) + 64'(fidx) : 64'd0);
      chk("fe_mask", first_err_mask, fmask);
      chk("state", 64'(state), (halt_cyc >= 0) ? 64'd2 : 64'd1);
      chk("ready_end", 64'(in_ready), 64'(halt_cyc < 0));
   endtask

   task automatic fill_match(input int n);
      logic [63:0] g;
      op.delete();
      og.delete();
      for (int i = 0; i < n; i++) begin
         g = {$urandom(), $urandom()};
         op.push_back(g);
         og.push_back(g);
      end
   endtask

   task automatic fill_random(input int n);
      logic [63:0] g, p;
      op.delete();
      og.delete();
      for (int i = 0; i < n; i++) begin
         g = {$urandom(), $urandom()};
         case ($urandom_range(3))
            0: p = g ^ (64'd1 << $urandom_range(63));
            1: p = {$urandom(), $urandom()};
            default: p = g;
         endcase
         op.push_back(p);
         og.push_back(g);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      clear       = 1'b0;
      halt_on_err = 1'b0;
      in_valid    = 1'b0;
      in_pred     = '0;
      in_gold     = '0;
`ifdef CHECKER_BITHIST_EN
      bit_sel     = '0;
`endif
      #12;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // 10 matching samples back-to-back
      do_start();
      fill_match(10);
      run_stream(1'b0, 100, 32'd0);
      do_clear();

      // single mismatch on sample 4, run continues
      do_start();
      fill_match(8);
      op[4] = 64'd0;
      og[4] = 64'h8000_0000_0000_0001;
      run_stream(1'b0, 100, 32'd0);
      do_clear();

      // halt on sample 2 with sample 3 in flight
      do_start();
      fill_match(6);
      op[2] = og[2] ^ 64'h0000_0100_0000_0000;
      run_stream(1'b1, 100, 32'd0);
      do_clear();

      // test_cnt saturation from a preloaded value
      do_start();
      force dut.u_test_cnt.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_test_cnt.cnt_q;
      fill_match(3);
      run_stream(1'b0, 100, 32'hFFFF_FFFE);
      do_clear();

      // random streams, each entered with clear+start together
      for (int r = 0; r < 6; r++) begin
         @(negedge clk);
         clear = 1'b1;
         start = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         start = 1'b0;
         chk("clr_start_state", 64'(state), 64'd1);
         chk("clr_start_cnt", 64'(test_cnt), 64'd0);
         fill_random($urandom_range(15, 40));
         run_stream(1'($urandom_range(1)), $urandom_range(50, 100), 32'd0);
         do_clear();
      end

`ifdef CHECKER_BITHIST_EN
      do_start();
      fill_match(5);
      foreach (op[i]) op[i] = og[i] ^ 64'h8000_0000_0000_0000;
      run_stream(1'b0, 100, 32'd0);
      bit_sel = 6'd63;
      @(negedge clk);
      @(negedge clk);
      chk("bit63_cnt", 64'(bit_err_cnt), 64'd5);
      bit_sel = 6'd0;
      @(negedge clk);
      @(negedge clk);
      chk("bit0_cnt", 64'(bit_err_cnt), 64'd0);
      do_clear();
`endif

      // asynchronous reset mid-run with a sample in stage 1
      do_start();
      halt_on_err = 1'b0;
      in_valid = 1'b1;
      in_pred  = 64'd1;
      in_gold  = 64'd0;
      repeat (3) @(negedge clk);
      chk("pre_rst_cnt", 64'(test_cnt), 64'd2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_cnt", 64'(test_cnt), 64'd0);
      chk("post_rst_state", 64'(state), 64'd0);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
